// File: rtl/wbr_ctrl_pkg.sv
// Shared wrapper definitions: the instruction opcodes, the default WIR width and the opcode decoder.
// Build option WBR_CTRL_SAFE_EN makes opcode 4 decode as WS_SAFE.
package wbr_ctrl_pkg;

    localparam int WIR_W_DEF = 3;

    typedef enum logic [2:0] {
        WS_BYPASS  = 3'd0,
        WS_EXTEST  = 3'd1,
        WS_INTEST  = 3'd2,
        WS_PRELOAD = 3'd3,
        WS_SAFE    = 3'd4
    } ws_instr_e;

    // Unknown opcodes fall back to bypass so a corrupted WIR never drives the boundary.
    function automatic ws_instr_e decode_op(input logic [31:0] op);
        ws_instr_e instr;
        case (op)
            32'd1:   instr = WS_EXTEST;
            32'd2:   instr = WS_INTEST;
            32'd3:   instr = WS_PRELOAD;
`ifdef WBR_CTRL_SAFE_EN
            32'd4:   instr = WS_SAFE;
`else
            32'd4:   instr = WS_BYPASS;
`endif
            default: instr = WS_BYPASS;
        endcase
        return instr;
    endfunction

    function automatic logic multi_hot4(input logic [3:0] v);
        return |(v & (v - 4'd1));
    endfunction

endpackage

// File: rtl/wbr_ctrl_if.sv
// Wrapper serial port and WBR cell control bundle for wbr_ctrl.
interface wbr_ctrl_if import wbr_ctrl_pkg::*; #(
    parameter int WIR_W = WIR_W_DEF
);
    logic             wsi;
    logic             selectwir;
    logic             capturewr;
    logic             shiftwr;
    logic             updatewr;
    logic             transferdr;
    logic             wbr_so;
    logic             wbr_si;
    logic             wso;
    logic             shift;
    logic             capture;
    logic             transfer;
    logic             update;
    logic             mode;
    logic             io_face;
    logic             safe;
    logic [WIR_W-1:0] wir_q;
    logic             proto_err;

    modport master (
        output wsi, selectwir, capturewr, shiftwr, updatewr, transferdr, wbr_so,
        input  wbr_si, wso, shift, capture, transfer, update, mode, io_face, safe,
               wir_q, proto_err
    );

    modport slave (
        input  wsi, selectwir, capturewr, shiftwr, updatewr, transferdr, wbr_so,
        output wbr_si, wso, shift, capture, transfer, update, mode, io_face, safe,
               wir_q, proto_err
    );
endinterface

// File: rtl/wbr_ctrl_wir.sv
// Wrapper instruction register: serial shift stage plus the parallel update (active) stage.
module wbr_ctrl_wir import wbr_ctrl_pkg::*; #(
    parameter int WIR_W = WIR_W_DEF
) (
    input  logic             wrck,
    input  logic             wrstn,
    input  logic             wsi,
    input  logic             cap_en,
    input  logic             shift_en,
    input  logic             upd_en,
    output logic [WIR_W-1:0] sr,
    output logic [WIR_W-1:0] wir_q
);
    logic [WIR_W-1:0] sr_r;
    logic [WIR_W-1:0] q_r;
    logic [WIR_W-1:0] cap_val_s;

    assign cap_val_s = {{(WIR_W-2){1'b0}}, 2'b01};

    // Shift stage: capture the fixed pattern or shift right with wsi entering the MSB.
    always_ff @(posedge wrck) begin
        if (!wrstn) begin
            sr_r <= {WIR_W{1'b0}};
        end else if (cap_en) begin
            sr_r <= cap_val_s;
        end else if (shift_en) begin
            sr_r <= {wsi, sr_r[WIR_W-1:1]};
        end else begin
            sr_r <= sr_r;
        end
    end

    // Update stage: the instruction only becomes active on an explicit update.
    always_ff @(posedge wrck) begin
        if (!wrstn) begin
            q_r <= {WIR_W{1'b0}};
        end else if (upd_en) begin
            q_r <= sr_r;
        end else begin
            q_r <= q_r;
        end
    end

    assign sr    = sr_r;
    assign wir_q = q_r;
endmodule

// File: rtl/wbr_ctrl.sv
// Wrapper boundary register controller: instruction decode, WBY, wso mux and protocol checking.
// Build option WBR_CTRL_SAFE_EN enables the WS_SAFE instruction and the registered safe output.
module wbr_ctrl import wbr_ctrl_pkg::*; #(
    parameter int WIR_W = WIR_W_DEF
) (
    input  logic       wrck,
    input  logic       wrstn,
    wbr_ctrl_if.slave  bus
);
    logic [WIR_W-1:0] sr_s;
    logic [WIR_W-1:0] wir_q_s;
    ws_instr_e        instr_s;
    ws_instr_e        next_instr_s;
    logic             viol_s;
    logic             gate_s;
    logic             wbr_sel_s;
    logic             wby_sel_s;
    logic             wir_cap_s;
    logic             wir_shift_s;
    logic             wir_upd_s;
    logic             wby_r;
    logic             mode_r;
    logic             io_face_r;
    logic             proto_err_r;
    logic             shift_s;
    logic             capture_s;
    logic             update_s;
    logic             transfer_s;
    logic             wso_s;

    assign viol_s       = multi_hot4({bus.capturewr, bus.shiftwr, bus.updatewr, bus.transferdr});
    assign gate_s       = wrstn & ~viol_s;
    assign instr_s      = decode_op(32'(wir_q_s));
    assign next_instr_s = decode_op(32'(sr_s));
    assign wbr_sel_s    = ~bus.selectwir & (instr_s != WS_BYPASS);
    assign wby_sel_s    = ~bus.selectwir & (instr_s == WS_BYPASS);
    assign wir_cap_s    = gate_s & bus.selectwir & bus.capturewr;
    assign wir_shift_s  = gate_s & bus.selectwir & bus.shiftwr;
    assign wir_upd_s    = gate_s & bus.selectwir & bus.updatewr;

    wbr_ctrl_wir #(.WIR_W(WIR_W)) u_wir (
        .wrck     (wrck),
        .wrstn    (wrstn),
        .wsi      (bus.wsi),
        .cap_en   (wir_cap_s),
        .shift_en (wir_shift_s),
        .upd_en   (wir_upd_s),
        .sr       (sr_s),
        .wir_q    (wir_q_s)
    );

    // Zero-latency cell strobes, suppressed in reset, on a violation or when the WBR is not selected.
    always_comb begin
        shift_s    = gate_s & wbr_sel_s & bus.shiftwr;
        capture_s  = gate_s & wbr_sel_s & bus.capturewr;
        update_s   = gate_s & wbr_sel_s & bus.updatewr;
        transfer_s = gate_s & wbr_sel_s & bus.transferdr;
    end

    // Single-bit bypass register.
    always_ff @(posedge wrck) begin
        if (!wrstn) begin
            wby_r <= 1'b0;
        end else if (gate_s && wby_sel_s && bus.capturewr) begin
            wby_r <= 1'b0;
        end else if (gate_s && wby_sel_s && bus.shiftwr) begin
            wby_r <= bus.wsi;
        end else begin
            wby_r <= wby_r;
        end
    end

    // Cell mode controls track the instruction being loaded so they change with wir_q.
    always_ff @(posedge wrck) begin
        if (!wrstn) begin
            mode_r    <= 1'b0;
            io_face_r <= 1'b0;
        end else if (wir_upd_s) begin
            case (next_instr_s)
                WS_EXTEST: begin mode_r <= 1'b1; io_face_r <= 1'b1; end
                WS_INTEST: begin mode_r <= 1'b1; io_face_r <= 1'b0; end
                WS_SAFE:   begin mode_r <= 1'b1; io_face_r <= 1'b1; end
                default:   begin mode_r <= 1'b0; io_face_r <= 1'b0; end
            endcase
        end else begin
            mode_r    <= mode_r;
            io_face_r <= io_face_r;
        end
    end

`ifdef WBR_CTRL_SAFE_EN
    logic safe_r;

    // Safe-state request follows the active instruction.
    always_ff @(posedge wrck) begin
        if (!wrstn) begin
            safe_r <= 1'b0;
        end else if (wir_upd_s) begin
            safe_r <= (next_instr_s == WS_SAFE);
        end else begin
            safe_r <= safe_r;
        end
    end

    assign bus.safe = safe_r;
`else
    assign bus.safe = 1'b0;
`endif

    // Sticky protocol error, cleared only by reset.
    always_ff @(posedge wrck) begin
        if (!wrstn) begin
            proto_err_r <= 1'b0;
        end else if (viol_s) begin
            proto_err_r <= 1'b1;
        end else begin
            proto_err_r <= proto_err_r;
        end
    end

    // Serial output selection.
    always_comb begin
        wso_s = wby_r;
        if (bus.selectwir) begin
            wso_s = sr_s[0];
        end else if (wbr_sel_s) begin
            wso_s = bus.wbr_so;
        end else begin
            wso_s = wby_r;
        end
    end

    assign bus.wbr_si    = bus.wsi;
    assign bus.wso       = wso_s;
    assign bus.shift     = shift_s;
    assign bus.capture   = capture_s;
    assign bus.update    = update_s;
    assign bus.transfer  = transfer_s;
    assign bus.mode      = mode_r;
    assign bus.io_face   = io_face_r;
    assign bus.wir_q     = wir_q_s;
    assign bus.proto_err = proto_err_r;
endmodule

// File: tb/tb_wbr_ctrl.sv
// Scoreboard bench for wbr_ctrl: the driver queues hand-computed mid-cycle expectations, a monitor checks them.
module tb_wbr_ctrl;
    import wbr_ctrl_pkg::*;

    localparam logic [4:0] C_IDLE = 5'b00000;
    localparam logic [4:0] C_SEL  = 5'b10000;
    localparam logic [4:0] C_WCAP = 5'b11000;
    localparam logic [4:0] C_WSH  = 5'b10100;
    localparam logic [4:0] C_WUPD = 5'b10010;
    localparam logic [4:0] C_CAP  = 5'b01000;
    localparam logic [4:0] C_SH   = 5'b00100;
    localparam logic [4:0] C_UPD  = 5'b00010;
    localparam logic [4:0] C_XFR  = 5'b00001;
    localparam logic [12:0] M_ALL  = 13'h1FFF;
    localparam logic [12:0] M_NONE = 13'h0000;

    logic wrck;
    logic wrstn;
    int   checks;
    int   errors;

    logic [12:0] exp_q[$];
    logic [12:0] mask_q[$];
    string       name_q[$];
    logic [12:0] mon_exp;
    logic [12:0] mon_mask;
    logic [12:0] mon_obs;
    string       mon_name;

    wbr_ctrl_if #(.WIR_W(3)) bus ();

    wbr_ctrl #(.WIR_W(3)) dut (
        .wrck  (wrck),
        .wrstn (wrstn),
        .bus   (bus)
    );

    initial wrck = 1'b0;
    always #5 wrck = ~wrck;

    // Observed vector, MSB first: wbr_si, wir_q[2:0], proto_err, safe, io_face, mode, transfer, update, capture, shift, wso
    function automatic logic [12:0] ex(input logic si, input logic [2:0] wq, input logic err,
                                       input logic sf, input logic io, input logic md,
                                       input logic xf, input logic up, input logic cp,
                                       input logic sh, input logic so);
        return {si, wq, err, sf, io, md, xf, up, cp, sh, so};
    endfunction

    always @(negedge wrck) begin
        if (exp_q.size() > 0) begin
            mon_exp  = exp_q.pop_front();
            mon_mask = mask_q.pop_front();
            mon_name = name_q.pop_front();
            mon_obs  = {bus.wbr_si, bus.wir_q, bus.proto_err, bus.safe, bus.io_face, bus.mode,
                        bus.transfer, bus.update, bus.capture, bus.shift, bus.wso};
            checks = checks + 1;
            if (((mon_obs ^ mon_exp) & mon_mask) !== 13'd0) begin
                errors = errors + 1;
                $display("FAIL %s: got %b want %b (mask %b)", mon_name, mon_obs, mon_exp, mon_mask);
            end
        end
    end

    task automatic cyc(input logic rn, input logic [4:0] ctl, input logic w, input logic so,
                       input logic [12:0] e, input logic [12:0] m, input string nm);
        @(posedge wrck);
        #1;
        wrstn = rn;
        {bus.selectwir, bus.capturewr, bus.shiftwr, bus.updatewr, bus.transferdr} = ctl;
        bus.wsi    = w;
        bus.wbr_so = so;
        if (m != M_NONE) begin
            exp_q.push_back(e);
            mask_q.push_back(m);
            name_q.push_back(nm);
        end
    endtask

    task automatic load_op(input logic [2:0] op);
        cyc(1'b1, C_WCAP, 1'b0, 1'b0, 13'd0, M_NONE, "");
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, C_WSH, op[i], 1'b0, 13'd0, M_NONE, "");
        end
        cyc(1'b1, C_WUPD, 1'b0, 1'b0, 13'd0, M_NONE, "");
    endtask

    initial begin
        logic [5:0] pat;
        checks = 0;
        errors = 0;
        wrstn  = 1'b0;
        {bus.selectwir, bus.capturewr, bus.shiftwr, bus.updatewr, bus.transferdr} = C_IDLE;
        bus.wsi    = 1'b0;
        bus.wbr_so = 1'b0;

        cyc(1'b0, C_IDLE, 1'b0, 1'b0, 13'd0, M_NONE, "");
        cyc(1'b0, C_IDLE, 1'b0, 1'b0, 13'd0, M_NONE, "");
        cyc(1'b1, C_IDLE, 1'b0, 1'b1, ex(0,3'd0,0,0,0,0,0,0,0,0,0), M_ALL, "reset_state");

        // EXTEST load: captured 001 appears on wso while shifting 1,0,0
        cyc(1'b1, C_WCAP, 1'b0, 1'b0, ex(0,3'd0,0,0,0,0,0,0,0,0,0), M_ALL, "wir_capture");
        cyc(1'b1, C_WSH,  1'b1, 1'b0, ex(1,3'd0,0,0,0,0,0,0,0,0,1), M_ALL, "wir_shift0");
        cyc(1'b1, C_WSH,  1'b0, 1'b0, ex(0,3'd0,0,0,0,0,0,0,0,0,0), M_ALL, "wir_shift1");
        cyc(1'b1, C_WSH,  1'b0, 1'b0, ex(0,3'd0,0,0,0,0,0,0,0,0,0), M_ALL, "wir_shift2");
        cyc(1'b1, C_WUPD, 1'b0, 1'b0, ex(0,3'd0,0,0,0,0,0,0,0,0,1), M_ALL, "wir_update");
        cyc(1'b1, C_IDLE, 1'b0, 1'b1, ex(0,3'd1,0,0,1,1,0,0,0,0,1), M_ALL, "extest_decode");
        cyc(1'b1, C_XFR,  1'b0, 1'b0, ex(0,3'd1,0,0,1,1,1,0,0,0,0), M_ALL, "extest_xfr");
        cyc(1'b1, C_UPD,  1'b0, 1'b0, ex(0,3'd1,0,0,1,1,0,1,0,0,0), M_ALL, "extest_upd");

        // INTEST: capture pulse, then six shifts with wso following wbr_so
        load_op(3'd2);
        cyc(1'b1, C_CAP, 1'b0, 1'b0, ex(0,3'd2,0,0,0,1,0,0,1,0,0), M_ALL, "intest_cap");
        pat = 6'b101101;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, C_SH, 1'b0, pat[i], ex(0,3'd2,0,0,0,1,0,0,0,1,pat[i]), M_ALL, "intest_shift");
        end
        cyc(1'b1, C_IDLE, 1'b0, 1'b0, ex(0,3'd2,0,0,0,1,0,0,0,0,0), M_ALL, "intest_idle");

        // Opcode 7 selects WBY
        load_op(3'd7);
        cyc(1'b1, C_SH,  1'b1, 1'b1, ex(1,3'd7,0,0,0,0,0,0,0,0,0), M_ALL, "wby_shift0");
        cyc(1'b1, C_SH,  1'b1, 1'b1, ex(1,3'd7,0,0,0,0,0,0,0,0,1), M_ALL, "wby_shift1");
        cyc(1'b1, C_CAP, 1'b0, 1'b1, ex(0,3'd7,0,0,0,0,0,0,0,0,1), M_ALL, "wby_cap");
        cyc(1'b1, C_UPD, 1'b0, 1'b1, ex(0,3'd7,0,0,0,0,0,0,0,0,0), M_ALL, "wby_upd");

        // Protocol violations leave WBY, WIR and wir_q untouched
        cyc(1'b1, C_SH, 1'b1, 1'b0, 13'd0, M_NONE, "");
        cyc(1'b1, 5'b01100, 1'b0, 1'b0, ex(0,3'd7,0,0,0,0,0,0,0,0,1), M_ALL, "viol_strobes");
        cyc(1'b1, C_IDLE,   1'b0, 1'b0, ex(0,3'd7,1,0,0,0,0,0,0,0,1), M_ALL, "viol_sticky");
        cyc(1'b1, 5'b11010, 1'b0, 1'b0, ex(0,3'd7,1,0,0,0,0,0,0,0,1), M_ALL, "viol_wir");
        cyc(1'b1, C_IDLE,   1'b0, 1'b0, ex(0,3'd7,1,0,0,0,0,0,0,0,1), M_ALL, "viol_wirq");
        cyc(1'b1, C_WSH,    1'b0, 1'b0, ex(0,3'd7,1,0,0,0,0,0,0,0,1), M_ALL, "viol_sr0");
        cyc(1'b1, C_WSH,    1'b0, 1'b0, ex(0,3'd7,1,0,0,0,0,0,0,0,1), M_ALL, "viol_sr1");

        // Opcode 4
        load_op(3'd4);
`ifdef WBR_CTRL_SAFE_EN
        cyc(1'b1, C_IDLE, 1'b0, 1'b0, ex(0,3'd4,1,1,1,1,0,0,0,0,0), M_ALL, "safe_decode");
        cyc(1'b1, C_SH,   1'b0, 1'b0, ex(0,3'd4,1,1,1,1,0,0,0,1,0), M_ALL, "safe_shift");
`else
        cyc(1'b1, C_IDLE, 1'b0, 1'b0, ex(0,3'd4,1,0,0,0,0,0,0,0,1), M_ALL, "safe_decode");
        cyc(1'b1, C_SH,   1'b0, 1'b0, ex(0,3'd4,1,0,0,0,0,0,0,0,1), M_ALL, "safe_shift");
`endif

        // Reset in the middle of a WIR operation
        load_op(3'd1);
        cyc(1'b1, C_WCAP, 1'b0, 1'b0, 13'd0, M_NONE, "");
        cyc(1'b1, C_SEL,  1'b0, 1'b0, ex(0,3'd1,1,0,1,1,0,0,0,0,1), M_ALL, "pre_rst");
        cyc(1'b0, C_SH,   1'b1, 1'b1, ex(1,3'd1,1,0,1,1,0,0,0,0,1), M_ALL, "rst_strobe");
        cyc(1'b1, C_SEL,  1'b0, 1'b0, ex(0,3'd0,0,0,0,0,0,0,0,0,0), M_ALL, "rst_cleared");
        cyc(1'b1, C_IDLE, 1'b0, 1'b1, ex(0,3'd0,0,0,0,0,0,0,0,0,0), M_ALL, "rst_outputs");
        load_op(3'd2);
        cyc(1'b1, C_IDLE, 1'b0, 1'b0, ex(0,3'd2,0,0,0,1,0,0,0,0,0), M_ALL, "fresh_load");
        cyc(1'b1, C_IDLE, 1'b0, 1'b0, 13'd0, M_NONE, "");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge wrck);
        end
        if (exp_q.size() > 0) begin
            errors = errors + 1;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wbr_ctrl.md
WBR_CTRL -- requirements
Module: wbr_ctrl

Interface
REQ-001 SHALL have parameter WIR_W, default 3: width of the wrapper instruction register (WIR); minimum 3.
REQ-002 SHALL have port wrck, input, 1: wrapper clock; all state changes on the rising edge.
REQ-003 SHALL have port wrstn, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port wsi, input, 1: wrapper serial input.
REQ-005 SHALL have ports selectwir, capturewr, shiftwr, updatewr and transferdr, each input, 1: WSP control strobes.
REQ-006 SHALL have port wbr_so, input, 1: serial output of the last WBR cell.
REQ-007 SHALL have port wbr_si, output, 1: serial input to the first WBR cell; equals wsi.
REQ-008 SHALL have port wso, output, 1: wrapper serial output.
REQ-009 SHALL have ports shift, capture, transfer, update, mode, io_face and safe, each output, 1: WBR cell controls.
REQ-010 SHALL have port wir_q, output, WIR_W: active instruction.
REQ-011 SHALL have port proto_err, output, 1: sticky protocol-violation flag.

Function
REQ-012 SHALL decode opcodes 0 = WS_BYPASS, 1 = WS_EXTEST, 2 = WS_INTEST, 3 = WS_PRELOAD, 4 = WS_SAFE; all other codes SHALL decode as WS_BYPASS.
REQ-013 SHALL load the WIR shift stage with {0…,2'b01} when selectwir and capturewr are asserted.
REQ-014 SHALL shift the WIR shift stage right when selectwir and shiftwr are asserted, with wsi entering the MSB.
REQ-015 SHALL copy the WIR shift stage to wir_q on the edge after selectwir and updatewr are asserted.
REQ-016 SHALL define "WBR selected" as selectwir=0 with wir_q in {EXTEST, INTEST, PRELOAD, SAFE}; "WBY selected" covers all other cases with selectwir=0.
REQ-017 SHALL drive shift, capture, update and transfer combinationally as the matching WSP strobe ANDed with WBR selected; this has zero latency.
REQ-018 SHALL set the 1-bit WBY to 0 on capturewr and to wsi on shiftwr while WBY is selected.
REQ-019 SHALL drive wso from WIR stage bit 0 when selectwir=1, from wbr_so when WBR is selected, and from WBY otherwise.
REQ-020 SHALL drive mode and io_face as registered decodes of wir_q, updated in the same cycle as wir_q: EXTEST 1/1, INTEST 1/0, SAFE 1/1, PRELOAD 0/0, BYPASS 0/0.
REQ-021 SHALL treat more than one of capturewr, shiftwr, updatewr, transferdr asserted in one cycle as a violation; on a violation, no register SHALL change, all strobe outputs SHALL be 0, and proto_err SHALL be set to 1.
REQ-022 SHALL clear proto_err only by reset.
REQ-023 SHALL apply an update on the same cycle the selectwir level changes, using the new selectwir level.

Reset
REQ-024 SHALL, with wrstn=0 at a rising edge, set wir_q to WS_BYPASS, the WIR shift stage to 0, WBY to 0, mode, io_face and safe to 0, and proto_err to 0.
REQ-025 SHALL hold shift, capture, update and transfer at 0 while wrstn=0.
REQ-026 SHALL have reset override every strobe and abort any in-progress shift; no partial instruction SHALL be retained.

Configuration
REQ-027 SHALL, when WBR_CTRL_SAFE_EN is defined, decode opcode 4 as WS_SAFE and drive safe as a registered 1 while wir_q=WS_SAFE.
REQ-028 SHALL, when WBR_CTRL_SAFE_EN is not defined, decode opcode 4 as WS_BYPASS and tie safe to 0.

Structure
REQ-029 SHALL place the opcode enum and the WIR_W default constant in package wbr_ctrl_pkg, shared with the WBR cells and the wrapper.
REQ-030 SHALL implement the WIR shift and update stages in sub-module wbr_ctrl_wir; decode, WBY, wso mux and error logic SHALL reside in wbr_ctrl.

Verification
REQ-031 SHALL cover this case: reset, then selectwir=1, capturewr, 3 shifts of wsi 1,0,0 (LSB first), then updatewr -> wir_q=1, mode=1, io_face=1, and wso during the shifts = 1,0,0 (captured 3'b001).
REQ-032 SHALL cover this case: with INTEST loaded and selectwir=0, assert capturewr 1 cycle then shiftwr 6 cycles -> capture pulses 1 cycle, shift is high 6 cycles, and wso follows wbr_so.
REQ-033 SHALL cover this case: load opcode 7, then shiftwr with wsi=1 -> wso=0 on the first shift cycle and 1 on the next; capture, shift and update stay 0.
REQ-034 SHALL cover this case: capturewr and shiftwr asserted together -> all strobes 0, WIR and WBY unchanged, and proto_err=1 until wrstn=0.
REQ-035 SHALL cover this case: opcode 4 loaded -> with WBR_CTRL_SAFE_EN, safe=1 and mode=1; without it, safe=0 and WBY is selected.
REQ-036 SHALL cover this case: wrstn=0 mid-shift of the WIR -> next cycle wir_q=0, all outputs 0, and a fresh shift loads correctly.
